snake_engine: RTL and testbench
===============================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter INIT_LEN, default 3, giving the initial snake length (2..16).
REQ-002 SHALL have parameter START_POS, default 8'h88, giving the initial head cell (row = pos/16, col = pos%16).
REQ-003 SHALL have parameter FOOD_INIT, default 8'h8C, giving the initial food cell.
REQ-004 SHALL have parameter LFSR_SEED, default 8'hA5, giving the nonzero food LFSR seed.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins or restarts a game.
REQ-008 SHALL have port tick, input, 1 bit: one-cycle step strobe.
REQ-009 SHALL have port dir, input, 2 bits: requested direction (0 up, 1 right, 2 down, 3 left).
REQ-010 SHALL have port pos, output, [255:0][7:0]: body cells, with pos[0] the head.
REQ-011 SHALL have port length, output, 8 bits: number of valid pos entries.
REQ-012 SHALL have port foodpos, output, 8 bits: food cell.
REQ-013 SHALL have port busy, output, 1 bit: high while in CHECK or FOOD.
REQ-014 SHALL have port game_over, output, 1 bit: high in DEAD.

Function
REQ-015 SHALL implement states IDLE, RUN, CHECK, FOOD, DEAD; all outputs SHALL be registered.
REQ-016 SHALL, in IDLE, move to RUN on start and ignore tick; if start and tick coincide, start wins and that tick is dropped.
REQ-017 SHALL, in RUN on tick, sample dir; a dir opposite the current direction is ignored and the current direction is kept.
REQ-018 SHALL compute the next head as up -16, down +16, left -1, right +1; leaving the 16x16 grid SHALL enter DEAD, with pos left unchanged.
REQ-019 SHALL, on a legal move, perform pos[i] <= pos[i-1] for i = 1..255 and pos[0] <= next head, all in the same cycle.
REQ-020 SHALL, if next head equals foodpos, increment length, saturating at 255 (no growth at 255), then enter FOOD; otherwise it SHALL enter CHECK.
REQ-021 SHALL, in CHECK, compare pos[0] against pos[k] for k = 1..length-1, one per cycle; on a match it SHALL enter DEAD, otherwise it SHALL return to RUN after length-1 cycles.
REQ-022 SHALL, in FOOD, use the LFSR value as the candidate cell and scan pos[0..length-1], one per cycle; on a match it SHALL advance the LFSR and restart the scan, on no match it SHALL commit foodpos, advance the LFSR, and return to RUN.
REQ-023 SHALL use an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, which never reaches 0, so cell 0 is never chosen as food.
REQ-024 SHALL drop ticks arriving while busy=1; they SHALL NOT be queued.
REQ-025 SHALL leave pos entries at index >= length undefined-but-stable; downstream consumers use only 0..length-1.
REQ-026 SHALL, in DEAD, hold all outputs; start SHALL reload the initial values and enter RUN.

Reset
REQ-027 SHALL, on reset in any state, in the next cycle set: state IDLE; direction right; pos[i] = START_POS - i for i < INIT_LEN and 0 otherwise; length = INIT_LEN; foodpos = FOOD_INIT; LFSR = LFSR_SEED; busy = 0; game_over = 0.

Configuration
REQ-028 SHALL, when SNAKE_WRAP_EN is defined, wrap grid edges (col 15 -> 0, row 0 -> 15, etc.) instead of entering DEAD; without it, edge exit SHALL cause DEAD per REQ-018.

Structure
REQ-029 SHALL take from package snake_pkg: GRID_W = 16, MAX_LEN = 255, typedef pos_t (8-bit), enum dir_t, and enum state_t.
REQ-030 SHALL instantiate the LFSR as sub-module food_lfsr, with seed, load, and advance ports.

Verification
REQ-031 SHALL verify: reset, start, tick with dir=1 -> pos[0..2] = 89, 88, 87; length = 3; busy high for 2 cycles.
REQ-032 SHALL verify: moving right, tick with dir=3 -> head 8A; the reversal is ignored.
REQ-033 SHALL verify: with FOOD_INIT = 89, tick right -> length = 4, and the new foodpos is nonzero and outside pos[0..3].
REQ-034 SHALL verify: 8 ticks up from 88 -> head 08, and a 9th up tick -> game_over = 1 (with SNAKE_WRAP_EN: head F8, game_over = 0).
REQ-035 SHALL verify: INIT_LEN = 5, ticks up, left, down -> game_over = 1 after the CHECK scan.
REQ-036 SHALL verify: reset asserted mid-CHECK -> next cycle state IDLE, busy = 0, outputs equal the REQ-027 values.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine.
package snake_pkg;

    localparam int GRID_W  = 16;
    localparam int MAX_LEN = 255;

    typedef logic [7:0] pos_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_FOOD,
        S_DEAD
    } state_t;

    // Up/down and left/right differ only in bit 1 of the encoding.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_engine_food_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing food candidate cells.
// A nonzero seed never reaches the all-zero state, so cell 0 is never offered.
module food_lfsr
    import snake_pkg::*;
(
    input  logic clk,
    input  pos_t seed,
    input  logic load,
    input  logic advance,
    output pos_t value
);

    // Load has priority over advance; the caller folds reset into load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: 16x16 grid, body shift register, serial self-collision
// scan and serial food placement scan.
// Optional build macro SNAKE_WRAP_EN: grid edges wrap instead of killing.
module snake_engine
    import snake_pkg::*;
#(
    parameter int   INIT_LEN  = 3,
    parameter pos_t START_POS = 8'h88,
    parameter pos_t FOOD_INIT = 8'h8C,
    parameter pos_t LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tick,
    input  logic [1:0]        dir,
    output logic [255:0][7:0] pos,
    output logic [7:0]        length,
    output logic [7:0]        foodpos,
    output logic              busy,
    output logic              game_over
);

    localparam logic [3:0] EDGE = 4'(GRID_W - 1);

    function automatic logic [255:0][7:0] init_body();
        logic [255:0][7:0] b;
        b = '0;
        for (int i = 0; i < INIT_LEN; i++) b[i] = 8'(START_POS - i);
        return b;
    endfunction

    localparam logic [255:0][7:0] INIT_BODY = init_body();

    state_t     state, state_nxt;
    dir_t       cur_dir, req_dir, move_dir;
    logic [3:0] head_row, head_col, nxt_row, nxt_col;
    pos_t       next_head;
    logic       off_grid;
    logic [7:0] idx, last_idx;
    pos_t       lfsr_value;
    logic       restart, check_hit, food_hit, scan_done;
    logic       lfsr_load, lfsr_adv;
    logic       busy_nxt, game_over_nxt;

    assign req_dir   = dir_t'(dir);
    assign head_row  = pos[0][7:4];
    assign head_col  = pos[0][3:0];
    assign next_head = {nxt_row, nxt_col};
    assign last_idx  = length - 8'd1;
    assign check_hit = (pos[idx] == pos[0]);
    assign food_hit  = (pos[idx] == lfsr_value);
    assign scan_done = (idx == last_idx);
    assign restart   = start && (state == S_IDLE || state == S_DEAD);
    assign lfsr_load = reset || restart;
    assign lfsr_adv  = (state == S_FOOD) && (food_hit || scan_done);

    food_lfsr u_food_lfsr (
        .clk     (clk),
        .seed    (LFSR_SEED),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    // Resolve the effective direction and the candidate head cell.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        move_dir = (req_dir == opposite(cur_dir)) ? cur_dir : req_dir;
        nxt_row  = head_row;
        nxt_col  = head_col;
        off_grid = 1'b0;
        unique case (move_dir)
            DIR_UP:    begin nxt_row = head_row - 4'd1; off_grid = (head_row == 4'd0); end
            DIR_DOWN:  begin nxt_row = head_row + 4'd1; off_grid = (head_row == EDGE); end
            DIR_LEFT:  begin nxt_col = head_col - 4'd1; off_grid = (head_col == 4'd0); end
            default:   begin nxt_col = head_col + 4'd1; off_grid = (head_col == EDGE); end
        endcase
`ifdef SNAKE_WRAP_EN
        // 4-bit row/col arithmetic already wraps; the edge is never fatal.
        off_grid = 1'b0;
`endif
    end

    // State register with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            game_over <= game_over_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (tick) begin
                         if (off_grid)                  state_nxt = S_DEAD;
                         else if (next_head == foodpos) state_nxt = S_FOOD;
                         else                           state_nxt = S_CHECK;
                     end
            S_CHECK: if (check_hit)      state_nxt = S_DEAD;
                     else if (scan_done) state_nxt = S_RUN;
            S_FOOD:  if (!food_hit && scan_done) state_nxt = S_RUN;
            S_DEAD:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/game_over leave flops.
    always_comb begin
        busy_nxt      = (state_nxt == S_CHECK) || (state_nxt == S_FOOD);
        game_over_nxt = (state_nxt == S_DEAD);
    end

    // Body, length, food, direction and scan index datapath.
    always_ff @(posedge clk) begin
        // NOTE: the body array is reset because its reset contents are the starting snake.
        if (reset || restart) begin
            pos     <= INIT_BODY;
            length  <= 8'(INIT_LEN);
            foodpos <= FOOD_INIT;
            cur_dir <= DIR_RIGHT;
            idx     <= 8'd0;
        end else begin
            unique case (state)
                S_RUN: if (tick && !off_grid) begin
                    pos     <= {pos[254:0], next_head};
                    cur_dir <= move_dir;
                    if (next_head == foodpos) begin
                        if (length != 8'(MAX_LEN)) length <= length + 8'd1;
                        idx <= 8'd0;
                    end else begin
                        idx <= 8'd1;
                    end
                end
                S_CHECK: idx <= idx + 8'd1;
                S_FOOD: begin
                    if (food_hit) begin
                        idx <= 8'd0;
                    end else if (scan_done) begin
                        foodpos <= lfsr_value;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: three instances (defaults, food next
// to the head, five-cell snake) share stimulus; vectors, corner sequences and
// a randomized run against a queue-based game model.
module tb_snake_engine;

    logic clk = 1'b0;
    logic reset, start, tick;
    logic [1:0] dir;

    logic [255:0][7:0] pos_a, pos_b, pos_c;
    logic [7:0] len_a, len_b, len_c, food_a, food_b, food_c;
    logic busy_a, busy_b, busy_c, over_a, over_b, over_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snake_engine dut_a (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
        .pos(pos_a), .length(len_a), .foodpos(food_a), .busy(busy_a), .game_over(over_a)
    );

    snake_engine #(.FOOD_INIT(8'h89)) dut_b (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
        .pos(pos_b), .length(len_b), .foodpos(food_b), .busy(busy_b), .game_over(over_b)
    );

    snake_engine #(.INIT_LEN(5)) dut_c (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
        .pos(pos_c), .length(len_c), .foodpos(food_c), .busy(busy_c), .game_over(over_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_all();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // One tick, then wait until every instance is idle; report busy cycles.
    task automatic do_tick(input logic [1:0] d, output int ba, output int bb, output int bc);
        int guard;
        ba = 0; bb = 0; bc = 0; guard = 0;
        @(negedge clk); tick = 1'b1; dir = d;
        @(negedge clk); tick = 1'b0;
        while ((busy_a || busy_b || busy_c) && guard < 3000) begin
            if (busy_a) ba++;
            if (busy_b) bb++;
            if (busy_c) bc++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            checks++; failures++;
            $display("FAIL tick_timeout: busy still high after %0d cycles, required to drop", guard);
        end
    endtask

    // ---------------- behavioural game model (default instance) -------------
    logic [7:0] body[$];
    int         m_dir;
    logic [7:0] m_food, m_lfsr;
    bit         m_dead;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic model_init();
        body = {8'h88, 8'h87, 8'h86};
        m_dir = 1; m_food = 8'h8C; m_lfsr = 8'hA5; m_dead = 1'b0;
    endtask

    task automatic model_step(input int d_in, output int exp_busy);
        int d, r, c, hit;
        logic [7:0] head, cand;
        d = d_in;
        exp_busy = 0;
        if (d == ((m_dir + 2) % 4)) d = m_dir;
        r = int'(body[0]) / 16;
        c = int'(body[0]) % 16;
        case (d)
            0: r = r - 1;
            1: c = c + 1;
            2: r = r + 1;
            default: c = c - 1;
        endcase
`ifdef SNAKE_WRAP_EN
        r = (r + 16) % 16;
        c = (c + 16) % 16;
`else
        if (r < 0 || r > 15 || c < 0 || c > 15) begin
            m_dead = 1'b1;
            return;
        end
`endif
        m_dir = d;
        head = 8'(r * 16 + c);
        body.push_front(head);
        if (head == m_food) begin
            if (body.size() > 255) void'(body.pop_back());
            forever begin
                cand = m_lfsr;
                hit = -1;
                foreach (body[j]) if (hit < 0 && body[j] == cand) hit = j;
                m_lfsr = lfsr_step(m_lfsr);
                if (hit >= 0) exp_busy += hit + 1;
                else begin
                    exp_busy += body.size();
                    m_food = cand;
                    break;
                end
            end
        end else begin
            void'(body.pop_back());
            exp_busy = body.size() - 1;
            for (int k = 1; k < body.size(); k++) begin
                if (body[k] == head) begin
                    exp_busy = k;
                    m_dead = 1'b1;
                    break;
                end
            end
        end
    endtask

    // ---------------- directed vectors --------------------------------------
    typedef struct {
        logic [1:0] d;
        logic [7:0] head;
        logic [7:0] len;
        logic       over;
        int         busy_cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ba, bb, bc, eb, mism;
        bit ok;

        vecs[0] = '{2'd3, 8'h8A, 8'd3, 1'b0, 2};  // reversal ignored
        vecs[1] = '{2'd0, 8'h7A, 8'd3, 1'b0, 2};
        vecs[2] = '{2'd2, 8'h6A, 8'd3, 1'b0, 2};  // reversal ignored
        vecs[3] = '{2'd3, 8'h69, 8'd3, 1'b0, 2};
        vecs[4] = '{2'd1, 8'h68, 8'd3, 1'b0, 2};  // reversal ignored
        vecs[5] = '{2'd2, 8'h78, 8'd3, 1'b0, 2};
        vecs[6] = '{2'd1, 8'h79, 8'd3, 1'b0, 2};
        vecs[7] = '{2'd0, 8'h69, 8'd3, 1'b0, 2};

        reset = 1'b1; start = 1'b0; tick = 1'b0; dir = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values
        check("rst_pos0", pos_a[0], 8'h88);
        check("rst_pos1", pos_a[1], 8'h87);
        check("rst_pos2", pos_a[2], 8'h86);
        check("rst_pos3", pos_a[3], 8'h00);
        check("rst_len", len_a, 8'd3);
        check("rst_food", food_a, 8'h8C);
        check("rst_busy", busy_a, 1'b0);
        check("rst_over", over_a, 1'b0);
        check("rst_c_pos4", pos_c[4], 8'h84);
        check("rst_c_pos5", pos_c[5], 8'h00);
        check("rst_c_len", len_c, 8'd5);
        check("rst_b_food", food_b, 8'h89);

        // First move right; instance b eats the adjacent food
        pulse_start();
        do_tick(2'd1, ba, bb, bc);
        check("first_pos0", pos_a[0], 8'h89);
        check("first_pos1", pos_a[1], 8'h88);
        check("first_pos2", pos_a[2], 8'h87);
        check("first_len", len_a, 8'd3);
        check("first_busy_cycles", ba, 2);
        check("eat_len", len_b, 8'd4);
        check("eat_food", food_b, 8'hA5);
        check("eat_busy_cycles", bb, 4);
        ok = (food_b != 8'h00);
        for (int i = 0; i < 4; i++) if (pos_b[i] == food_b) ok = 1'b0;
        check("eat_food_free_cell", ok, 1'b1);

        // Table-driven walk
        for (int v = 0; v < 8; v++) begin
            do_tick(vecs[v].d, ba, bb, bc);
            check($sformatf("vec%0d_head", v), pos_a[0], vecs[v].head);
            check($sformatf("vec%0d_len", v), len_a, vecs[v].len);
            check($sformatf("vec%0d_over", v), over_a, vecs[v].over);
            check($sformatf("vec%0d_busy", v), ba, vecs[v].busy_cycles);
        end

        // Tick during CHECK is dropped, not queued
        @(negedge clk); tick = 1'b1; dir = 2'd3;
        @(negedge clk); tick = 1'b1; dir = 2'd0;
        @(negedge clk); tick = 1'b0;
        do_tick(2'd3, ba, bb, bc);
        check("busy_drop_head", pos_a[0], 8'h67);

        // Reset in the middle of CHECK
        reset_all();
        pulse_start();
        @(negedge clk); tick = 1'b1; dir = 2'd1;
        @(negedge clk); tick = 1'b0;
        check("midchk_busy_before", busy_a, 1'b1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("midchk_busy", busy_a, 1'b0);
        check("midchk_over", over_a, 1'b0);
        check("midchk_pos0", pos_a[0], 8'h88);
        check("midchk_pos1", pos_a[1], 8'h87);
        check("midchk_pos2", pos_a[2], 8'h86);
        check("midchk_len", len_a, 8'd3);
        check("midchk_food", food_a, 8'h8C);
        // IDLE ignores tick
        @(negedge clk); tick = 1'b1; dir = 2'd1;
        @(negedge clk); tick = 1'b0;
        check("idle_tick_head", pos_a[0], 8'h88);
        check("idle_tick_busy", busy_a, 1'b0);
        // start and tick together: start wins, tick dropped
        @(negedge clk); start = 1'b1; tick = 1'b1; dir = 2'd1;
        @(negedge clk); start = 1'b0; tick = 1'b0;
        check("start_tick_head", pos_a[0], 8'h88);
        check("start_tick_busy", busy_a, 1'b0);
        do_tick(2'd1, ba, bb, bc);
        check("after_start_head", pos_a[0], 8'h89);

        // Top edge
        reset_all();
        pulse_start();
        for (int i = 0; i < 8; i++) do_tick(2'd0, ba, bb, bc);
        check("edge_head_08", pos_a[0], 8'h08);
        check("edge_alive", over_a, 1'b0);
        do_tick(2'd0, ba, bb, bc);
`ifdef SNAKE_WRAP_EN
        check("edge_head_after", pos_a[0], 8'hF8);
        check("edge_over", over_a, 1'b0);
`else
        check("edge_head_after", pos_a[0], 8'h08);
        check("edge_over", over_a, 1'b1);
        check("edge_busy_cycles", ba, 0);
`endif

        // Self-collision with a five-cell snake
        reset_all();
        pulse_start();
        do_tick(2'd0, ba, bb, bc);
        do_tick(2'd3, ba, bb, bc);
        check("self_alive_before", over_c, 1'b0);
        do_tick(2'd2, ba, bb, bc);
        check("self_over", over_c, 1'b1);
        check("self_busy_cycles", bc, 4);
        check("self_head", pos_c[0], 8'h87);
        check("self_short_alive", over_a, 1'b0);
        // DEAD holds outputs across ticks
        do_tick(2'd2, ba, bb, bc);
        check("dead_hold_head", pos_c[0], 8'h87);
        check("dead_hold_over", over_c, 1'b1);

        // Randomized play against the model
        reset_all();
        pulse_start();
        model_init();
        for (int n = 0; n < 300; n++) begin
            int d;
            d = int'($urandom_range(0, 3));
            model_step(d, eb);
            do_tick(2'(d), ba, bb, bc);
            check($sformatf("rnd%0d_len", n), len_a, 32'(body.size()));
            check($sformatf("rnd%0d_food", n), food_a, m_food);
            check($sformatf("rnd%0d_over", n), over_a, m_dead);
            check($sformatf("rnd%0d_busy", n), ba, eb);
            mism = 0;
            for (int i = 0; i < body.size(); i++) if (pos_a[i] !== body[i]) mism++;
            check($sformatf("rnd%0d_body_mismatches", n), mism, 0);
            if (m_dead) begin
                pulse_start();
                model_init();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
